uart_tx_arbiter: RTL

Shares one UART transmit byte stream between `NUM_REQ` independent requesters (e.g. per-core or per-subsystem console writers) so their output never interleaves mid-line. Each requester pushes bytes into a private FIFO. A round-robin line-lock arbiter forwards one requester's bytes at a time to a single downstream serializer over a valid/ready byte interface. The block sits between the console-producing masters and the UART TX serializer or DPI UART model.

---
 rtl/uart_tx_arbiter.sv | 274 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
//==============================================================================
// Module   : uart_tx_arbiter
// Desc     : Shares one UART transmit byte stream between NUM_REQ requesters.
//            Every requester owns a private byte FIFO. A round-robin line-lock
//            arbiter forwards one requester's bytes at a time to a single
//            valid/ready byte sink. The lock is released after the LF (8'h0A)
//            byte is accepted, or after TIMEOUT_CYC cycles with an empty
//            granted FIFO, so console lines from different masters never
//            interleave.
// Ports    : clk_i        - clock, rising edge
//            rst_i        - synchronous active-high reset
//            req_valid_i  - per-requester byte valid
//            req_data_i   - per-requester byte, requester n at [8n+7:8n]
//            req_ready_o  - per-requester FIFO can accept a byte
//            tx_valid_o   - output byte valid
//            tx_data_o    - output byte
//            tx_ready_i   - downstream accepts the byte
//            grant_o      - index of the locked requester (held while idle)
//            busy_o       - arbiter holds a line lock
// Macro    : UART_ARB_TAG_EN - when defined, every lock starts with the two
//            prefix bytes "<'0'+grant>" and ':' before any FIFO data.
// Revision : 1.0 - initial release
//==============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                                           clk_i,
    input  logic                                           rst_i,
    input  logic [NUM_REQ-1:0]                             req_valid_i,
    input  logic [8*NUM_REQ-1:0]                           req_data_i,
    output logic [NUM_REQ-1:0]                             req_ready_o,
    output logic                                           tx_valid_o,
    output logic [7:0]                                     tx_data_o,
    input  logic                                           tx_ready_i,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_o,
    output logic                                           busy_o
);

    localparam int c_GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int c_PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CW = c_PW + 1;
    localparam int c_TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [7:0] c_LF      = 8'h0A;
    localparam logic [7:0] c_TAG_BASE = 8'h30;
    localparam logic [7:0] c_TAG_SEP  = 8'h3A;

`ifdef UART_ARB_TAG_EN
    localparam int c_SW = 2;
`else
    localparam int c_SW = 1;
`endif

    localparam logic [c_SW-1:0] c_ST_IDLE    = c_SW'(0);
    localparam logic [c_SW-1:0] c_ST_LOCK    = c_SW'(1);
`ifdef UART_ARB_TAG_EN
    localparam logic [c_SW-1:0] c_ST_TAG_ID  = c_SW'(2);
    localparam logic [c_SW-1:0] c_ST_TAG_SEP = c_SW'(3);
`endif

    // -------------------------------------------------------------------------
    // Declarations
    // -------------------------------------------------------------------------
    logic [c_SW-1:0]   r_state;
    logic [c_SW-1:0]   w_state_nxt;
    logic [c_GW-1:0]   r_grant;
    logic [c_GW-1:0]   r_last_grant;
    logic [c_TW-1:0]   r_idle_cnt;

    logic [NUM_REQ-1:0] w_full;
    logic [NUM_REQ-1:0] w_empty;
    logic [NUM_REQ-1:0] w_push;
    logic [NUM_REQ-1:0] w_pop;
    logic [NUM_REQ-1:0] w_req_avail;
    logic [7:0]         w_head [NUM_REQ];

    logic               w_gnt_empty;
    logic [7:0]         w_gnt_head;
    logic               w_arb_found;
    logic [c_GW-1:0]    w_arb_idx;
    int                 w_cand;

    logic               w_tx_valid;
    logic [7:0]         w_tx_data;
    logic               w_pop_any;
    logic               w_enter_lock;

    // -------------------------------------------------------------------------
    // Per-requester FIFOs
    // -------------------------------------------------------------------------
    generate
        for (genvar n = 0; n < NUM_REQ; n++) begin : g_fifo
            logic [7:0]      r_mem [FIFO_DEPTH];
            logic [c_PW-1:0] r_wr_ptr;
            logic [c_PW-1:0] r_rd_ptr;
            logic [c_CW-1:0] r_count;

            assign w_full[n]      = (r_count == c_CW'(FIFO_DEPTH));
            assign w_empty[n]     = (r_count == '0);
            assign w_head[n]      = r_mem[r_rd_ptr];
            // Ready depends on fullness only, so a pop in the same cycle never
            // opens room for a push into a full FIFO.
            assign req_ready_o[n] = !w_full[n] && !rst_i;
            assign w_push[n]      = req_valid_i[n] && req_ready_o[n];
            assign w_pop[n]       = w_pop_any && (r_grant == c_GW'(n));

            always_ff @(posedge clk_i) begin
                if (w_push[n]) begin
                    r_mem[r_wr_ptr] <= req_data_i[8*n +: 8];
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_count  <= '0;
                end else begin
                    if (w_push[n]) begin
                        r_wr_ptr <= r_wr_ptr + c_PW'(1);
                    end
                    if (w_pop[n]) begin
                        r_rd_ptr <= r_rd_ptr + c_PW'(1);
                    end
                    case ({w_push[n], w_pop[n]})
                        2'b10:   r_count <= r_count + c_CW'(1);
                        2'b01:   r_count <= r_count - c_CW'(1);
                        default: r_count <= r_count;
                    endcase
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Granted FIFO view
    // -------------------------------------------------------------------------
    always_comb begin
        w_gnt_empty = 1'b1;
        w_gnt_head  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant == c_GW'(i)) begin
                w_gnt_empty = w_empty[i];
                w_gnt_head  = w_head[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Round-robin pick: first requester strictly after r_last_grant that holds
    // data or is pushing this cycle. Counting the incoming push lets a byte
    // written into an idle block be presented on the very next cycle.
    // -------------------------------------------------------------------------
    assign w_req_avail = ~w_empty | w_push;

    always_comb begin
        w_arb_found = 1'b0;
        w_arb_idx   = r_last_grant;
        w_cand      = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = int'(r_last_grant) + k;
            if (w_cand >= NUM_REQ) begin
                w_cand = w_cand - NUM_REQ;
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!w_arb_found && (j == w_cand) && w_req_avail[j]) begin
                    w_arb_found = 1'b1;
                    w_arb_idx   = c_GW'(j);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Line-lock state machine
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tx_valid  = 1'b0;
        w_tx_data   = '0;
        w_pop_any   = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (w_arb_found) begin
`ifdef UART_ARB_TAG_EN
                    w_state_nxt = c_ST_TAG_ID;
`else
                    w_state_nxt = c_ST_LOCK;
`endif
                end
            end

`ifdef UART_ARB_TAG_EN
            c_ST_TAG_ID: begin
                w_tx_valid = 1'b1;
                w_tx_data  = c_TAG_BASE + 8'(r_grant);
                if (tx_ready_i) begin
                    w_state_nxt = c_ST_TAG_SEP;
                end
            end

            c_ST_TAG_SEP: begin
                w_tx_valid = 1'b1;
                w_tx_data  = c_TAG_SEP;
                if (tx_ready_i) begin
                    w_state_nxt = c_ST_LOCK;
                end
            end
`endif

            c_ST_LOCK: begin
                w_tx_valid = !w_gnt_empty;
                w_tx_data  = w_gnt_head;
                w_pop_any  = !w_gnt_empty && tx_ready_i && !rst_i;
                if (w_pop_any && (w_gnt_head == c_LF)) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (w_gnt_empty && (r_idle_cnt == c_TW'(TIMEOUT_CYC - 1))) begin
                    // Only reachable with nothing on offer, so no valid byte
                    // is ever withdrawn.
                    w_state_nxt = c_ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    assign w_enter_lock = (w_state_nxt == c_ST_LOCK) && (r_state != c_ST_LOCK);

    // -------------------------------------------------------------------------
    // Grant bookkeeping and idle counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_grant      <= '0;
            r_last_grant <= c_GW'(NUM_REQ - 1);
            r_idle_cnt   <= '0;
        end else begin
            if ((r_state == c_ST_IDLE) && w_arb_found) begin
                r_grant      <= w_arb_idx;
                r_last_grant <= w_arb_idx;
            end
            if (w_enter_lock || w_pop_any) begin
                r_idle_cnt <= '0;
            end else if ((r_state == c_ST_LOCK) && w_gnt_empty) begin
                r_idle_cnt <= r_idle_cnt + c_TW'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs; reset forces the documented quiet values immediately.
    // -------------------------------------------------------------------------
    assign tx_valid_o = w_tx_valid && !rst_i;
    assign tx_data_o  = rst_i ? 8'h00 : w_tx_data;
    assign grant_o    = rst_i ? '0 : r_grant;
    assign busy_o     = (r_state != c_ST_IDLE) && !rst_i;

endmodule
`default_nettype wire
